cpu_ctrl_fsm: RTL and testbench

CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

---
 rtl/cpu_ctrl_if.sv | 37 +++
 rtl/cpu_ctrl_fsm.sv | 127 ++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_if.sv
// Handshake and status bundle between the core control FSM and the rest of the core.
interface cpu_ctrl_if;
  // Instruction fetch handshake
  logic        ifu_req;
  logic        ifu_ack;
  logic        inst_en;
  // Decoder class flags
  logic        dec_is_load;
  logic        dec_is_store;
  logic        dec_is_ebreak;
  logic        dec_is_inv;
  // Load/store unit handshake
  logic        lsu_req;
  logic        lsu_wen;
  logic        lsu_ack;
  // Writeback strobes
  logic        rf_wen;
  logic        pc_wen;
  // Status
  logic        halt;
  logic [1:0]  halt_code;
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;
  logic [2:0]  state_o;

  modport master (
    output ifu_req, inst_en, lsu_req, lsu_wen, rf_wen, pc_wen,
    output halt, halt_code, cycle_cnt, instret_cnt, state_o,
    input  ifu_ack, lsu_ack, dec_is_load, dec_is_store, dec_is_ebreak, dec_is_inv
  );

  modport slave (
    input  ifu_req, inst_en, lsu_req, lsu_wen, rf_wen, pc_wen,
    input  halt, halt_code, cycle_cnt, instret_cnt, state_o,
    output ifu_ack, lsu_ack, dec_is_load, dec_is_store, dec_is_ebreak, dec_is_inv
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle core sequencer: IDLE -> FETCH -> DECODE -> [MEM] -> WB, with a bus-wait
// timeout and an absorbing HALT state that records why the core stopped.
module cpu_ctrl_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  cpu_ctrl_if.master    bus
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  // Wait counter value during the last cycle an ack is still accepted.
  localparam logic [15:0] WaitLast = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CodeEbreak  = 2'b01;
  localparam logic [1:0] CodeInvalid = 2'b10;
  localparam logic [1:0] CodeTimeout = 2'b11;

  state_e      state_q;
  logic [15:0] wait_q;
  logic        store_q;
  logic        halt_q;
  logic [1:0]  halt_code_q;
  logic [63:0] cycle_q;
  logic [63:0] instret_q;

  logic        dec_invalid;
  assign dec_invalid = bus.dec_is_inv | (bus.dec_is_load & bus.dec_is_store);

  // Sequencer state, wait timer, store flag, halt cause and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      store_q     <= 1'b0;
      halt_q      <= 1'b0;
      halt_code_q <= 2'b00;
      cycle_q     <= '0;
      instret_q   <= '0;
    end else begin
      if (state_q != StHalt) begin
        cycle_q <= cycle_q + 64'd1;
      end
      unique case (state_q)
        StIdle: begin
          state_q <= StFetch;
          wait_q  <= '0;
        end
        StFetch: begin
          // An ack on the final allowed cycle wins over the timeout.
          if (bus.ifu_ack) begin
            state_q <= StDecode;
          end else if (wait_q == WaitLast) begin
            state_q     <= StHalt;
            halt_q      <= 1'b1;
            halt_code_q <= CodeTimeout;
          end else begin
            wait_q <= wait_q + 16'd1;
          end
        end
        StDecode: begin
          store_q <= bus.dec_is_store;
          if (dec_invalid) begin
            state_q     <= StHalt;
            halt_q      <= 1'b1;
            halt_code_q <= CodeInvalid;
          end else if (bus.dec_is_ebreak) begin
            // ebreak retires even though the core stops.
            state_q     <= StHalt;
            halt_q      <= 1'b1;
            halt_code_q <= CodeEbreak;
            instret_q   <= instret_q + 64'd1;
          end else if (bus.dec_is_load | bus.dec_is_store) begin
            state_q <= StMem;
            wait_q  <= '0;
          end else begin
            state_q <= StWb;
          end
        end
        StMem: begin
          if (bus.lsu_ack) begin
            state_q <= StWb;
          end else if (wait_q == WaitLast) begin
            state_q     <= StHalt;
            halt_q      <= 1'b1;
            halt_code_q <= CodeTimeout;
          end else begin
            wait_q <= wait_q + 16'd1;
          end
        end
        StWb: begin
          state_q   <= StFetch;
          wait_q    <= '0;
          instret_q <= instret_q + 64'd1;
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Requests and strobes decode straight from the current state; reset clears them at once.
  assign bus.ifu_req     = (state_q == StFetch);
  assign bus.inst_en     = (state_q == StFetch) & bus.ifu_ack;
  assign bus.lsu_req     = (state_q == StMem);
  assign bus.lsu_wen     = (state_q == StMem) & store_q;
  assign bus.pc_wen      = (state_q == StWb);
  assign bus.rf_wen      = (state_q == StWb) & ~store_q;
  assign bus.halt        = halt_q;
  assign bus.halt_code   = halt_code_q;
  assign bus.cycle_cnt   = cycle_q;
  assign bus.instret_cnt = instret_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed self-checking bench for cpu_ctrl_fsm with a short bus timeout.
module tb_cpu_ctrl_fsm;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cpu_ctrl_if bus ();

  cpu_ctrl_fsm #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset across one edge, release, then step out of IDLE into FETCH.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Deliver an instruction from the first FETCH cycle and land in DECODE.
  task automatic fetch_now();
    bus.ifu_ack = 1'b1;
    tick();
    bus.ifu_ack = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.ifu_ack       = 1'b0;
    bus.lsu_ack       = 1'b0;
    bus.dec_is_load   = 1'b0;
    bus.dec_is_store  = 1'b0;
    bus.dec_is_ebreak = 1'b0;
    bus.dec_is_inv    = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_state", 64'(bus.state_o), 64'd0);
    chk("rst_halt", 64'(bus.halt), 64'd0);
    chk("rst_code", 64'(bus.halt_code), 64'd0);
    chk("rst_cycle", bus.cycle_cnt, 64'd0);
    chk("rst_instret", bus.instret_cnt, 64'd0);
    chk("rst_ifu_req", 64'(bus.ifu_req), 64'd0);

    // ALU instruction, ack on 3rd FETCH cycle
    rst = 1'b0;
    #1;
    chk("alu_idle", 64'(bus.state_o), 64'd0);
    tick();
    chk("alu_fetch1", 64'(bus.state_o), 64'd1);
    chk("alu_ifu_req", 64'(bus.ifu_req), 64'd1);
    chk("alu_cycle1", bus.cycle_cnt, 64'd1);
    tick();
    tick();
    chk("alu_inst_en_idle", 64'(bus.inst_en), 64'd0);
    bus.ifu_ack = 1'b1;
    #1;
    chk("alu_inst_en", 64'(bus.inst_en), 64'd1);
    tick();
    bus.ifu_ack = 1'b0;
    #1;
    chk("alu_decode", 64'(bus.state_o), 64'd2);
    chk("alu_inst_en_once", 64'(bus.inst_en), 64'd0);
    tick();
    chk("alu_wb", 64'(bus.state_o), 64'd4);
    chk("alu_pc_wen", 64'(bus.pc_wen), 64'd1);
    chk("alu_rf_wen", 64'(bus.rf_wen), 64'd1);
    tick();
    chk("alu_refetch", 64'(bus.state_o), 64'd1);
    chk("alu_cycle6", bus.cycle_cnt, 64'd6);
    chk("alu_instret", bus.instret_cnt, 64'd1);

    // Load, lsu_ack on 2nd MEM cycle
    fetch_now();
    bus.dec_is_load = 1'b1;
    tick();
    bus.dec_is_load = 1'b0;
    #1;
    chk("ld_mem", 64'(bus.state_o), 64'd3);
    chk("ld_lsu_req", 64'(bus.lsu_req), 64'd1);
    chk("ld_lsu_wen", 64'(bus.lsu_wen), 64'd0);
    tick();
    bus.lsu_ack = 1'b1;
    #1;
    chk("ld_mem2", 64'(bus.state_o), 64'd3);
    tick();
    bus.lsu_ack = 1'b0;
    #1;
    chk("ld_wb", 64'(bus.state_o), 64'd4);
    chk("ld_rf_wen", 64'(bus.rf_wen), 64'd1);
    chk("ld_wb_lsu_wen", 64'(bus.lsu_wen), 64'd0);
    tick();
    chk("ld_instret", bus.instret_cnt, 64'd2);

    // Store: store flag must hold after the decoder flag drops
    fetch_now();
    bus.dec_is_store = 1'b1;
    tick();
    bus.dec_is_store = 1'b0;
    #1;
    chk("st_lsu_wen1", 64'(bus.lsu_wen), 64'd1);
    tick();
    chk("st_lsu_wen2", 64'(bus.lsu_wen), 64'd1);
    bus.lsu_ack = 1'b1;
    tick();
    bus.lsu_ack = 1'b0;
    #1;
    chk("st_wb", 64'(bus.state_o), 64'd4);
    chk("st_rf_wen", 64'(bus.rf_wen), 64'd0);
    chk("st_pc_wen", 64'(bus.pc_wen), 64'd1);
    chk("st_wb_lsu_wen", 64'(bus.lsu_wen), 64'd0);
    tick();
    chk("st_instret", bus.instret_cnt, 64'd3);

    // ifu_ack on the 4th (last allowed) FETCH cycle
    tick();
    tick();
    tick();
    chk("tof_fetch4", 64'(bus.state_o), 64'd1);
    fetch_now();
    chk("tof_decode", 64'(bus.state_o), 64'd2);
    tick();
    tick();

    // lsu_ack on the 4th (last allowed) MEM cycle
    fetch_now();
    bus.dec_is_load = 1'b1;
    tick();
    bus.dec_is_load = 1'b0;
    tick();
    tick();
    tick();
    chk("tom_mem4", 64'(bus.state_o), 64'd3);
    bus.lsu_ack = 1'b1;
    tick();
    bus.lsu_ack = 1'b0;
    #1;
    chk("tom_wb", 64'(bus.state_o), 64'd4);
    tick();
    chk("tom_instret", bus.instret_cnt, 64'd5);

    // Asynchronous reset mid-MEM
    fetch_now();
    bus.dec_is_store = 1'b1;
    tick();
    bus.dec_is_store = 1'b0;
    #1;
    chk("arst_pre_lsu_req", 64'(bus.lsu_req), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_lsu_req", 64'(bus.lsu_req), 64'd0);
    chk("arst_lsu_wen", 64'(bus.lsu_wen), 64'd0);
    chk("arst_state", 64'(bus.state_o), 64'd0);
    chk("arst_cycle", bus.cycle_cnt, 64'd0);
    chk("arst_instret", bus.instret_cnt, 64'd0);
    bus.lsu_ack = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("arst_idle", 64'(bus.state_o), 64'd0);
    tick();
    chk("arst_fetch", 64'(bus.state_o), 64'd1);
    chk("arst_no_replay", 64'(bus.lsu_req), 64'd0);
    bus.lsu_ack = 1'b0;

    // FETCH timeout: no ack for 4 cycles
    tick();
    tick();
    tick();
    chk("tof4_fetch", 64'(bus.state_o), 64'd1);
    tick();
    chk("tof_halt", 64'(bus.state_o), 64'd5);
    chk("tof_halt_flag", 64'(bus.halt), 64'd1);
    chk("tof_code", 64'(bus.halt_code), 64'd3);
    chk("tof_ifu_req", 64'(bus.ifu_req), 64'd0);
    chk("tof_cycle", bus.cycle_cnt, 64'd5);
    chk("tof_instret", bus.instret_cnt, 64'd0);

    // MEM timeout
    do_reset();
    fetch_now();
    bus.dec_is_load = 1'b1;
    tick();
    bus.dec_is_load = 1'b0;
    tick();
    tick();
    tick();
    chk("tom4_mem", 64'(bus.state_o), 64'd3);
    tick();
    chk("tom_halt", 64'(bus.state_o), 64'd5);
    chk("tom_code", 64'(bus.halt_code), 64'd3);
    chk("tom_lsu_req", 64'(bus.lsu_req), 64'd0);

    // ebreak: retires, then HALT absorbs everything
    do_reset();
    fetch_now();
    bus.dec_is_ebreak = 1'b1;
    tick();
    bus.dec_is_ebreak = 1'b0;
    chk("eb_halt", 64'(bus.state_o), 64'd5);
    chk("eb_code", 64'(bus.halt_code), 64'd1);
    chk("eb_instret", bus.instret_cnt, 64'd1);
    chk("eb_cycle", bus.cycle_cnt, 64'd3);
    bus.ifu_ack = 1'b1;
    bus.lsu_ack = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    chk("eb_cycle_frozen", bus.cycle_cnt, 64'd3);
    chk("eb_still_halt", 64'(bus.state_o), 64'd5);
    chk("eb_code_held", 64'(bus.halt_code), 64'd1);
    chk("eb_inst_en", 64'(bus.inst_en), 64'd0);
    chk("eb_ifu_req", 64'(bus.ifu_req), 64'd0);
    chk("eb_pc_wen", 64'(bus.pc_wen), 64'd0);
    chk("eb_instret_held", bus.instret_cnt, 64'd1);
    bus.ifu_ack = 1'b0;
    bus.lsu_ack = 1'b0;

    // Invalid beats ebreak
    do_reset();
    fetch_now();
    bus.dec_is_inv    = 1'b1;
    bus.dec_is_ebreak = 1'b1;
    tick();
    bus.dec_is_inv    = 1'b0;
    bus.dec_is_ebreak = 1'b0;
    chk("inv_halt", 64'(bus.state_o), 64'd5);
    chk("inv_code", 64'(bus.halt_code), 64'd2);
    chk("inv_instret", bus.instret_cnt, 64'd0);

    // Load and store together is invalid
    do_reset();
    fetch_now();
    bus.dec_is_load  = 1'b1;
    bus.dec_is_store = 1'b1;
    tick();
    bus.dec_is_load  = 1'b0;
    bus.dec_is_store = 1'b0;
    chk("ldst_halt", 64'(bus.state_o), 64'd5);
    chk("ldst_code", 64'(bus.halt_code), 64'd2);
    chk("ldst_lsu_req", 64'(bus.lsu_req), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
